fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per sample, signed.
REQ-002 Parameter CNT_WIDTH, default 16: width of the delivered-sample counter.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port fifo_empty  input  1: upstream FIFO has no readable word.
REQ-006 Port fifo_rd  output  1: pop request to the upstream FIFO; the word is consumed at the clock edge where fifo_rd=1.
REQ-007 Port fifo_r_data  input  DATA_WIDTH signed: FIFO head word, combinationally valid whenever fifo_empty=0.
REQ-008 Port out_valid  output  1: out_data holds a sample.
REQ-009 Port out_ready  input  1: downstream accepts the sample; transfer occurs when out_valid=1 and out_ready=1.
REQ-010 Port out_data  output  DATA_WIDTH signed: registered output sample.
REQ-011 Port flush  input  1: discard all held samples.
REQ-012 Port count  output  CNT_WIDTH: number of completed output transfers, saturating.
REQ-013 Port busy  output  1: held samples exist or the FIFO is non-empty.

Function
REQ-014 The block SHALL hold up to two samples: an output register (out_data) and a skid register.
REQ-015 The FSM SHALL have three states: S_EMPTY (no sample held), S_ONE (output register valid), S_FULL (output and skid registers valid).
REQ-016 out_valid SHALL be 1 exactly when the state is S_ONE or S_FULL.
REQ-017 fifo_rd SHALL equal ~fifo_empty & ~flush & (state != S_FULL) & reset deasserted, with no combinational path from out_ready.
REQ-018 In S_EMPTY, a pop SHALL load out_data with fifo_r_data and go to S_ONE.
REQ-019 In S_ONE with a pop and no transfer, the block SHALL load skid with fifo_r_data and go to S_FULL.
REQ-020 In S_ONE with a pop and a transfer, the block SHALL load out_data with fifo_r_data and stay in S_ONE.
REQ-021 In S_ONE with a transfer and no pop, the block SHALL go to S_EMPTY.
REQ-022 In S_FULL, a transfer SHALL copy skid into out_data and go to S_ONE; no pop occurs in S_FULL.
REQ-023 Samples SHALL leave in FIFO order with none lost or duplicated; the latency from pop to out_valid is 1 cycle.
REQ-024 When flush=1, the next state SHALL be S_EMPTY regardless of out_ready; a transfer coinciding with flush still increments count.
REQ-025 count SHALL increment by 1 per transfer and hold at 2^CNT_WIDTH-1; flush SHALL not modify count.
REQ-026 busy SHALL equal (state != S_EMPTY) | ~fifo_empty.

Reset
REQ-027 While reset=0, the state SHALL be S_EMPTY, out_data=0, skid=0, count=0, out_valid=0 and fifo_rd=0.
REQ-028 Reset asserted mid-operation SHALL take effect immediately without waiting for a clock; held samples are discarded and nothing is popped until reset deasserts.

Structure
REQ-029 A shared package fifo_rd_pkg SHALL hold the state enum typedef (S_EMPTY, S_ONE, S_FULL) and the default DATA_WIDTH/CNT_WIDTH constants.
REQ-030 The saturating counter SHALL be a sub-module named sat_counter (parameter WIDTH, inputs clk, reset, inc; output value).

Verification
REQ-031 Reset: reset=0 with fifo_empty=0 -> fifo_rd=0, out_valid=0, count=0 throughout; after release, the first pop occurs on the first edge.
REQ-032 Streaming: FIFO holds 5,-3,7 and out_ready=1 -> out_data is 5,-3,7 on three consecutive cycles, then out_valid=0 and count=3.
REQ-033 Backpressure: FIFO holds 10,20,30 and out_ready=0 -> exactly two pops, fifo_rd=0 afterwards, out_data=10 held; raise out_ready -> 10,20,30 delivered in order and count=3.
REQ-034 Flush: in S_FULL (10 out, 20 skid, 30 in FIFO), pulse flush one cycle -> out_valid=0 next cycle, count unchanged, 30 still in FIFO and popped the following cycle.
REQ-035 Saturation: with CNT_WIDTH=2, perform 5 transfers -> count reads 1,2,3,3,3.
REQ-036 Mid-run reset: assert reset in S_FULL between clock edges -> out_valid=0 and out_data=0 immediately, count=0, no further pop while reset=0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO stream reader: state encoding and
// parameter defaults used by the top and its testbench.
package fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } rd_state_e;

    // A state holds a presentable sample whenever it is not S_EMPTY.
    function automatic logic state_has_sample(input rd_state_e s);
        return (s != S_EMPTY);
    endfunction

    // Room for another word exists in every state except S_FULL.
    function automatic logic state_has_room(input rd_state_e s);
        return (s != S_FULL);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; used to tally output transfers.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             at_max;

    assign at_max = &value_q;

    always_comb begin
        value_d = value_q;
        if (inc && !at_max) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls signed samples from an upstream FIFO into a two-deep output stage
// (output register plus skid register) and presents them as a valid/ready stream.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_EMPTY | nothing held, out_valid low
//   S_ONE   | out_data holds a sample, skid unused
//   S_FULL  | out_data and skid both hold samples, no popping
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fifo_empty,
    output logic                         fifo_rd,
    input  logic signed [DATA_WIDTH-1:0] fifo_r_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         flush,
    output logic [CNT_WIDTH-1:0]         count,
    output logic                         busy
);

    rd_state_e                    state_q;
    rd_state_e                    state_d;
    logic signed [DATA_WIDTH-1:0] out_data_q;
    logic signed [DATA_WIDTH-1:0] out_data_d;
    logic signed [DATA_WIDTH-1:0] skid_q;
    logic signed [DATA_WIDTH-1:0] skid_d;

    logic pop;
    logic xfer;

    // Pop depends only on registered state and upstream/flush inputs, never on
    // out_ready, so the FIFO handshake does not chain into the downstream one.
    assign pop  = ~fifo_empty & ~flush & state_has_room(state_q) & reset;
    assign xfer = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;

        unique case (state_q)
            S_EMPTY: begin
                if (pop) begin
                    out_data_d = fifo_r_data;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (pop && !xfer) begin
                    skid_d  = fifo_r_data;
                    state_d = S_FULL;
                end else if (pop && xfer) begin
                    out_data_d = fifo_r_data;
                end else if (xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (xfer) begin
                    out_data_d = skid_q;
                    state_d    = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            out_data_q <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            skid_q     <= skid_d;
        end
    end

    // A transfer that lands on the same edge as a flush still counts.
    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_sat_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (xfer),
        .value(count)
    );

    assign fifo_rd   = pop;
    assign out_valid = state_has_sample(state_q);
    assign out_data  = out_data_q;
    assign busy      = state_has_sample(state_q) | ~fifo_empty;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_stream_reader;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fifo_empty;
    logic              fifo_rd;
    logic signed [7:0] fifo_r_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              flush;
    logic [15:0]       count;
    logic              busy;

    logic              fifo_rd2;
    logic              out_valid2;
    logic signed [7:0] out_data2;
    logic [1:0]        count2;
    logic              busy2;

    int fq[$];
    int held[$];
    int mcnt;
    int nchecks;
    int nerr;
    int npops;
    logic popped;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(rst_n), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_r_data(fifo_r_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .count(count), .busy(busy)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd2),
        .fifo_r_data(fifo_r_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .flush(flush), .count(count2), .busy(busy2)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty  = (fq.size() == 0);
        fifo_r_data = (fq.size() > 0) ? 8'(fq[0]) : 8'sd0;
    endtask

    task automatic push(input int v);
        fq.push_back(v);
        refresh();
    endtask

    // One clock: note whether the DUT popped at the edge, then update the FIFO.
    task automatic tick();
        @(posedge clk);
        popped = fifo_rd;
        #1;
        if (popped) begin
            npops++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        refresh();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        fq.delete();
        refresh();
        tick();
        tick();
        rst_n = 1'b1;
        npops = 0;
    endtask

    // Reference model: the stage is a queue of at most two samples.
    initial begin
        mcnt = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                held.delete();
                mcnt = 0;
            end else begin
                bit xf, pp;
                xf = (held.size() > 0) && out_ready;
                pp = !fifo_empty && !flush && (held.size() < 2);
                if (xf) begin
                    void'(held.pop_front());
                    mcnt++;
                end
                if (flush) held.delete();
                if (pp) held.push_back(int'(fifo_r_data));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("valid", int'(out_valid), int'(held.size() > 0));
                if (held.size() > 0) chk("data", int'(out_data), held[0]);
                chk("fifo_rd", int'(fifo_rd), int'(!fifo_empty && !flush && held.size() < 2));
                chk("busy", int'(busy), int'(held.size() > 0 || !fifo_empty));
                chk("count", int'(count), (mcnt > 65535) ? 65535 : mcnt);
                chk("count_sat2", int'(count2), (mcnt > 3) ? 3 : mcnt);
                chk("valid2", int'(out_valid2), int'(held.size() > 0));
            end else begin
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_rd", int'(fifo_rd), 0);
                chk("rst_count", int'(count), 0);
                chk("rst_data", int'(out_data), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_exp[5];
        int rdy_pat;
        nchecks = 0;
        nerr    = 0;
        npops   = 0;
        popped  = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        refresh();

        // Reset held with a non-empty FIFO: nothing popped, outputs quiet.
        push(1);
        push(2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r031_rd", int'(fifo_rd), 0);
            chk("r031_valid", int'(out_valid), 0);
            chk("r031_count", int'(count), 0);
        end
        rst_n = 1'b1;
        tick();
        chk("r031_first_pop", int'(popped), 1);
        chk("r031_first_data", int'(out_data), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Streaming with out_ready high.
        do_reset();
        out_ready = 1'b1;
        push(5);
        push(-3);
        push(7);
        tick();
        chk("r032_d0", int'(out_data), 5);
        tick();
        chk("r032_d1", int'(out_data), -3);
        tick();
        chk("r032_d2", int'(out_data), 7);
        tick();
        chk("r032_valid_end", int'(out_valid), 0);
        chk("r032_count", int'(count), 3);

        // Backpressure: two pops then stall with 10 held.
        do_reset();
        push(10);
        push(20);
        push(30);
        for (int i = 0; i < 5; i++) tick();
        chk("r033_pops", npops, 2);
        chk("r033_rd", int'(fifo_rd), 0);
        chk("r033_hold", int'(out_data), 10);
        out_ready = 1'b1;
        tick();
        chk("r033_d1", int'(out_data), 20);
        tick();
        chk("r033_d2", int'(out_data), 30);
        tick();
        chk("r033_valid_end", int'(out_valid), 0);
        chk("r033_count", int'(count), 3);

        // Flush from S_FULL with one word left upstream.
        do_reset();
        push(10);
        push(20);
        push(30);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("r034_popped_on_flush", int'(popped), 0);
        chk("r034_valid", int'(out_valid), 0);
        chk("r034_count", int'(count), 0);
        chk("r034_fifo_left", fq.size(), 1);
        tick();
        chk("r034_repop", int'(popped), 1);
        chk("r034_data", int'(out_data), 30);

        // Saturation on the 2-bit counter instance.
        do_reset();
        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push(i);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("r035_count2", int'(count2), sat_exp[i]);
        end

        // Reset asserted between edges while full.
        do_reset();
        push(10);
        push(20);
        push(30);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("r036_valid", int'(out_valid), 0);
        chk("r036_data", int'(out_data), 0);
        chk("r036_count", int'(count), 0);
        chk("r036_rd", int'(fifo_rd), 0);
        npops = 0;
        tick();
        tick();
        chk("r036_no_pop", npops, 0);
        chk("r036_fifo_left", fq.size(), 1);
        rst_n = 1'b1;

        // Mixed traffic: irregular ready, a mid-stream flush, late arrivals.
        do_reset();
        rdy_pat = 32'b1011_0010_1110_0101_1001_1101_0011_0110;
        for (int i = 0; i < 8; i++) push(-100 + 27 * i);
        for (int i = 0; i < 24; i++) begin
            out_ready = rdy_pat[i];
            flush     = (i == 9);
            if (i == 14) begin
                push(99);
                push(-128);
                push(127);
            end
            tick();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("mix_drained", int'(out_valid), 0);
        chk("mix_fifo_empty", fq.size(), 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
